// File: rtl/freq_note_decoder.sv
// Tone period decoder.
// Measures the period of a square-wave tone in CLK cycles and classifies it to a 4-bit note
// code (0=none, 1=C4, 2=D, 3=E, 4=F, 5=G, 6=A, 7=B, 8=C5). A new note is only reported after
// STABLE consecutive periods of the same class. The note drops to 0 when no rising edge is
// seen for TIMEOUT cycles.
//
// Ports:
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   FREQ_IN  asynchronous tone input
//   note     decoded note code
//   Led      one-hot of note, bit7=C4 .. bit0=C5, zero when note=0
//   VALID    high while note != 0
//   NEW      one-cycle pulse whenever note changes
//   period   last measured period in cycles
module freq_note_decoder #(
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TOL     = 4000,
  parameter int unsigned STABLE  = 3,
  parameter int unsigned P_C4    = 382219,
  parameter int unsigned P_D     = 340530,
  parameter int unsigned P_E     = 303370,
  parameter int unsigned P_F     = 286344,
  parameter int unsigned P_G     = 255102,
  parameter int unsigned P_A     = 227273,
  parameter int unsigned P_B     = 202478,
  parameter int unsigned P_C5    = 191113
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FREQ_IN,
  output logic [3:0]  note,
  output logic [7:0]  Led,
  output logic        VALID,
  output logic        NEW,
  output logic [19:0] period
);

  localparam int unsigned StW = $clog2(STABLE + 1);
  localparam logic [StW-1:0] StableCnt = StW'(STABLE);
  localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StArmed, StLock} state_e;

  state_e state_q, state_d;

  logic [1:0]     sync_q;
  logic           prev_q;
  logic           rise_q;
  logic [19:0]    cnt_q, cnt_d;
  logic [19:0]    period_q, period_d;
  logic [3:0]     cand_q, cand_d;
  logic [StW-1:0] stab_q, stab_d;
  logic [3:0]     note_q, note_d;
  logic           new_q, new_d;

  logic [3:0]     cls;
  logic [StW-1:0] stab_nxt;
  logic           confirm;
  logic           timeout;

  function automatic logic near(input int unsigned pv, input int unsigned nom);
    return (pv + TOL >= nom) && (pv <= nom + TOL);
  endfunction

  // Lowest code wins when tolerance windows overlap.
  function automatic logic [3:0] classify(input logic [19:0] p);
    int unsigned pv;
    pv = 32'(p);
    if (near(pv, P_C4)) return 4'd1;
    if (near(pv, P_D))  return 4'd2;
    if (near(pv, P_E))  return 4'd3;
    if (near(pv, P_F))  return 4'd4;
    if (near(pv, P_G))  return 4'd5;
    if (near(pv, P_A))  return 4'd6;
    if (near(pv, P_B))  return 4'd7;
    if (near(pv, P_C5)) return 4'd8;
    return 4'd0;
  endfunction

  // Two-flop synchronizer followed by a registered rising-edge detect.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], FREQ_IN};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  always_comb begin
    cls     = classify(cnt_q);
    timeout = (cnt_q == TimeoutCnt);
    if (cls == cand_q) begin
      stab_nxt = (stab_q == StableCnt) ? stab_q : stab_q + 1'b1;
    end else begin
      stab_nxt = StW'(1);
    end
    confirm = (stab_nxt == StableCnt);
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic. A rise wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rise_q) state_d = StArmed;
      StArmed, StLock: begin
        if (rise_q) begin
          if (confirm) state_d = StLock;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next-state logic.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    cand_d   = cand_q;
    stab_d   = stab_q;
    note_d   = note_q;
    new_d    = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = rise_q ? 20'd1 : 20'd0;
    end else if (rise_q) begin
      cnt_d    = 20'd1;
      period_d = cnt_q;
      cand_d   = cls;
      stab_d   = stab_nxt;
      if (confirm && (cls != note_q)) begin
        note_d = cls;
        new_d  = 1'b1;
      end
    end else if (timeout) begin
      // Clear history so a returning tone needs a full set of periods again.
      cnt_d  = 20'd0;
      cand_d = 4'd0;
      stab_d = '0;
      if (note_q != 4'd0) begin
        note_d = 4'd0;
        new_d  = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      period_q <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      note_q   <= '0;
      new_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      note_q   <= note_d;
      new_q    <= new_d;
    end
  end

  always_comb begin
    case (note_q)
      4'd1:    Led = 8'h80;
      4'd2:    Led = 8'h40;
      4'd3:    Led = 8'h20;
      4'd4:    Led = 8'h10;
      4'd5:    Led = 8'h08;
      4'd6:    Led = 8'h04;
      4'd7:    Led = 8'h02;
      4'd8:    Led = 8'h01;
      default: Led = 8'h00;
    endcase
  end

  assign note   = note_q;
  assign VALID  = (note_q != 4'd0);
  assign NEW    = new_q;
  assign period = period_q;

endmodule

// File: tb/tb_freq_note_decoder.sv
// Scoreboard bench for freq_note_decoder with scaled-down periods (nominals /1000).
module tb_freq_note_decoder;

  localparam int TO = 500;
  localparam int TL = 4;
  localparam int ST = 3;

  int nom[8] = '{382, 340, 303, 286, 255, 227, 202, 191};

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FREQ_IN = 1'b0;
  logic [3:0]  note;
  logic [7:0]  Led;
  logic        VALID;
  logic        NEW;
  logic [19:0] period;

  freq_note_decoder #(
    .TIMEOUT(TO), .TOL(TL), .STABLE(ST),
    .P_C4(382), .P_D(340), .P_E(303), .P_F(286),
    .P_G(255), .P_A(227), .P_B(202), .P_C5(191)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FREQ_IN(FREQ_IN),
    .note(note), .Led(Led), .VALID(VALID), .NEW(NEW), .period(period)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int note;
    int period;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: note from the last STABLE period classes since the tone appeared.
  bit armed = 1'b0;
  int hist[$];
  int m_note = 0;
  int m_period = 0;
  int prev_p = 0;

  function automatic int classify(input int p);
    for (int k = 0; k < 8; k++) begin
      if (p >= nom[k] - TL && p <= nom[k] + TL) return k + 1;
    end
    return 0;
  endfunction

  function automatic logic [7:0] onehot(input int n);
    logic [7:0] top;
    top = 8'h80;
    if (n == 0) return 8'h00;
    return top >> (n - 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.note = m_note;
    e.period = m_period;
    q.push_back(e);
  endtask

  task automatic model_timeout();
    if (armed) begin
      armed = 1'b0;
      hist.delete();
      if (m_note != 0) begin
        m_note = 0;
        push_exp();
      end
    end
  endtask

  task automatic model_gap(input int gap);
    int c;
    bit same;
    if (!armed) begin
      armed = 1'b1;
    end else if (gap > TO) begin
      model_timeout();
      armed = 1'b1;
    end else begin
      c = classify(gap);
      m_period = gap;
      hist.push_back(c);
      if (hist.size() > ST) void'(hist.pop_front());
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != c) same = 1'b0;
      if (hist.size() == ST && same && c != m_note) begin
        m_note = c;
        push_exp();
      end
    end
  endtask

  // Monitor: every NEW pulse must match the next expected note change.
  always @(negedge CLK) begin
    if (RESET_N && NEW === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_new: got note %0d with no change expected (t=%0t)", note, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("new_note", int'(note), e.note);
        chk("new_led", int'(Led), int'(onehot(e.note)));
        chk("new_valid", int'(VALID), int'(e.note != 0));
        chk("new_period", int'(period), e.period);
      end
    end
  end

  task automatic check_state(input string nm);
    chk({nm, "_note"}, int'(note), m_note);
    chk({nm, "_led"}, int'(Led), int'(onehot(m_note)));
    chk({nm, "_valid"}, int'(VALID), int'(m_note != 0));
    chk({nm, "_new"}, int'(NEW), 0);
    chk({nm, "_period"}, int'(period), m_period);
  endtask

  // n rising edges, each starting a period of p cycles.
  task automatic tone(input int p, input int n);
    int h;
    h = p / 2;
    repeat (n) begin
      @(negedge CLK);
      FREQ_IN = 1'b1;
      model_gap(prev_p);
      prev_p = p;
      repeat (h) @(negedge CLK);
      FREQ_IN = 1'b0;
      repeat (p - h - 1) @(negedge CLK);
    end
  endtask

  task automatic silence(input bit hi, input int n);
    if (hi) begin
      @(negedge CLK);
      FREQ_IN = 1'b1;
      model_gap(prev_p);
    end
    model_timeout();
    repeat (n) @(negedge CLK);
    FREQ_IN = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_note"}, int'(note), 0);
    chk({nm, "_led"}, int'(Led), 0);
    chk({nm, "_valid"}, int'(VALID), 0);
    chk({nm, "_new"}, int'(NEW), 0);
    chk({nm, "_period"}, int'(period), 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    FREQ_IN = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge CLK);
    check_reset_outputs("rst_next");
    chk("rst_queue_empty", q.size(), 0);
    q.delete();
    armed = 1'b0;
    hist.delete();
    m_note = 0;
    m_period = 0;
    prev_p = 0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int sel, p, k, n;
    repeat (4) @(negedge CLK);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);

    tone(227, 4);
    check_state("lock_a");
    tone(191, 3);
    check_state("c5_two_periods");
    tone(191, 1);
    check_state("c5_locked");

    tone(382, 4);
    check_state("c4_locked");
    silence(1'b1, TO + 20);
    check_state("timeout_high");
    tone(382, 3);
    check_state("relock_partial");
    tone(382, 1);
    check_state("relock_c4");

    tone(227, 4);
    @(negedge CLK);
    FREQ_IN = 1'b1;
    model_gap(prev_p);
    prev_p = 227;
    repeat (40) @(negedge CLK);
    do_reset();
    tone(227, 4);
    check_state("after_reset_a");

    silence(1'b0, TO + 20);
    check_state("timeout_low");
    tone(270, 4);
    check_state("between_classes");

    tone(259, 4);
    check_state("g_upper_edge");
    tone(260, 4);
    check_state("g_past_edge");

    tone(255, 4);
    check_state("lock_g");
    tone(TO, 4);
    check_state("gap_equals_timeout");

    for (int b = 0; b < 25; b++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6) begin
        k = $urandom_range(0, 7);
        p = nom[k] + $urandom_range(0, 2 * TL + 4) - (TL + 2);
      end else if (sel == 7) begin
        p = $urandom_range(150, 420);
      end else if (sel == 8) begin
        p = $urandom_range(0, 1) ? TO : TO + 1;
      end else begin
        p = $urandom_range(260, 280);
      end
      n = $urandom_range(1, 5);
      tone(p, n);
    end
    check_state("random_end");

    silence(1'b0, TO + 20);
    check_state("final_timeout");
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    total++;
    $display("FAIL watchdog: got no end of stimulus expected finish before %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
